// File: rtl/alu_acc.sv
// 8-bit accumulator ALU with Z/C/N flags and an EN/BUSY/DONE handshake.
// Define ALU_MUL_EN to compile in the 8-cycle shift-add multiplier.
module alu_acc #(
  parameter int WIDTH     = 8,
  parameter int MUL_STEPS = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] alu_data_i,
  input  logic [3:0]       op_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] acc_out_o,
  output logic [WIDTH-1:0] mul_hi_o,
  output logic             z_flag_o,
  output logic             c_flag_o,
  output logic             n_flag_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LD  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1000;
  localparam logic [3:0] OP_SHL = 4'b1001;
  localparam logic [3:0] OP_SHR = 4'b1010;
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;

  generate
    if (MUL_STEPS != WIDTH) begin : g_bad_steps
      $error("alu_acc: MUL_STEPS must equal WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             z_q, z_d, c_q, c_d, n_q, n_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   sum_wide;
  logic             alu_c, upd_zn, upd_c, wr_acc, accept_alu;

  // Single-cycle result and flag-update decode; CMP computes a SUB result
  // for the flags only.
  always_comb begin
    sum_wide = '0;
    alu_res  = acc_q;
    alu_c    = c_q;
    upd_zn   = 1'b1;
    upd_c    = 1'b0;
    wr_acc   = 1'b1;
    case (op_i)
      OP_LD:  alu_res = alu_data_i;
      OP_ADD: begin
        sum_wide = {1'b0, acc_q} + {1'b0, alu_data_i};
        alu_res  = sum_wide[WIDTH-1:0];
        alu_c    = sum_wide[WIDTH];
        upd_c    = 1'b1;
      end
      OP_ADC: begin
        sum_wide = {1'b0, acc_q} + {1'b0, alu_data_i} + {{WIDTH{1'b0}}, c_q};
        alu_res  = sum_wide[WIDTH-1:0];
        alu_c    = sum_wide[WIDTH];
        upd_c    = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        sum_wide = {1'b0, acc_q} - {1'b0, alu_data_i};
        alu_res  = sum_wide[WIDTH-1:0];
        alu_c    = sum_wide[WIDTH];
        upd_c    = 1'b1;
        wr_acc   = (op_i == OP_SUB);
      end
      OP_AND: alu_res = acc_q & alu_data_i;
      OP_OR:  alu_res = acc_q | alu_data_i;
      OP_XOR: alu_res = acc_q ^ alu_data_i;
      OP_NOT: alu_res = ~acc_q;
      OP_SHL: begin
        alu_res = {acc_q[WIDTH-2:0], 1'b0};
        alu_c   = acc_q[WIDTH-1];
        upd_c   = 1'b1;
      end
      OP_SHR: begin
        alu_res = {1'b0, acc_q[WIDTH-1:1]};
        alu_c   = acc_q[0];
        upd_c   = 1'b1;
      end
      default: begin
        upd_zn = 1'b0;
        wr_acc = 1'b0;
      end
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(MUL_STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(MUL_STEPS - 1);

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplr_q, mplr_d, mul_hi_q, mul_hi_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, step_sum;

  assign accept_alu = en_i && (state_q == IDLE) && (op_i != OP_MUL);
`else
  assign accept_alu = en_i;
`endif

  // Next state: single-cycle commit in IDLE, plus the multiply FSM when built.
  always_comb begin
    acc_d  = acc_q;
    z_d    = z_q;
    c_d    = c_q;
    n_d    = n_q;
    done_d = 1'b0;
`ifdef ALU_MUL_EN
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    prod_d   = prod_q;
    mul_hi_d = mul_hi_q;
    step_sum = prod_q + (mplr_q[count_q] ? ({{WIDTH{1'b0}}, mcand_q} << count_q) : '0);
`endif
    if (accept_alu) begin
      if (wr_acc) acc_d = alu_res;
      if (upd_zn) begin
        z_d = (alu_res == '0);
        n_d = alu_res[WIDTH-1];
      end
      if (upd_c) c_d = alu_c;
      done_d = 1'b1;
    end
`ifdef ALU_MUL_EN
    case (state_q)
      IDLE: begin
        if (en_i && op_i == OP_MUL) begin
          state_d = MUL_RUN;
          mcand_d = acc_q;
          mplr_d  = alu_data_i;
          prod_d  = '0;
          count_d = '0;
        end
      end
      MUL_RUN: begin
        prod_d  = step_sum;
        count_d = count_q + 1'b1;
        if (count_q == LAST_STEP) begin
          state_d  = IDLE;
          acc_d    = step_sum[WIDTH-1:0];
          mul_hi_d = step_sum[2*WIDTH-1:WIDTH];
          z_d      = (step_sum == '0);
          n_d      = step_sum[2*WIDTH-1];
          c_d      = (step_sum[2*WIDTH-1:WIDTH] != '0);
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      n_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      z_q    <= z_d;
      c_q    <= c_d;
      n_q    <= n_d;
      done_q <= done_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      prod_q   <= '0;
      mul_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      prod_q   <= prod_d;
      mul_hi_q <= mul_hi_d;
    end
  end

  assign mul_hi_o = mul_hi_q;
  assign busy_o   = (state_q == MUL_RUN);
`else
  assign mul_hi_o = '0;
  assign busy_o   = 1'b0;
`endif

  assign acc_out_o = acc_q;
  assign z_flag_o  = z_q;
  assign c_flag_o  = c_q;
  assign n_flag_o  = n_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_alu_acc.sv
// Self-checking bench for alu_acc: an arithmetic reference model compared on
// every cycle, plus hand-computed checkpoints. Honours ALU_MUL_EN.
module tb_alu_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] aluData;
  logic [3:0] op;
  logic       en;
  logic [7:0] accOut, mulHi;
  logic       zFlag, cFlag, nFlag, busy, done;

  int testsRun = 0;
  int testsFailed = 0;
  bit checkEnable = 1'b0;

  alu_acc dut (
    .clk_i(clk), .rst_i(rst), .alu_data_i(aluData), .op_i(op), .en_i(en),
    .acc_out_o(accOut), .mul_hi_o(mulHi), .z_flag_o(zFlag), .c_flag_o(cFlag),
    .n_flag_o(nFlag), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Reference model: what the outputs must be after each rising edge.
  logic [7:0]  mAcc = 8'h00, mHi = 8'h00;
  logic        mZ = 1'b0, mC = 1'b0, mN = 1'b0, mBusy = 1'b0, mDone = 1'b0;
  logic [15:0] mProd = 16'h0000;
  int          mRemain = 0;

  always @(posedge clk) begin
    int a, b, t;
    logic [7:0] r;
    bit flagsZn, writeAcc;
    mDone = 1'b0;
    if (rst) begin
      mAcc = 0; mHi = 0; mZ = 0; mC = 0; mN = 0; mBusy = 0; mRemain = 0;
    end else if (mRemain > 0) begin
      mRemain = mRemain - 1;
      if (mRemain == 0) begin
        mHi = mProd[15:8];
        mAcc = mProd[7:0];
        mZ = (mProd == 0);
        mN = mProd[15];
        mC = (mProd[15:8] != 0);
        mBusy = 0;
        mDone = 1;
      end
    end else if (en) begin
      a = int'(mAcc);
      b = int'(aluData);
      r = mAcc;
      flagsZn = 1;
      writeAcc = 1;
      mDone = 1;
      case (op)
        4'h1: r = aluData;
        4'h2: begin t = a + b; r = 8'(t); mC = (t > 255); end
        4'h3: begin t = a + b + int'(mC); r = 8'(t); mC = (t > 255); end
        4'h4: begin r = 8'(a - b); mC = (a < b); end
        4'h5: r = mAcc & aluData;
        4'h6: r = mAcc | aluData;
        4'h7: r = mAcc ^ aluData;
        4'h8: r = 8'(255 - a);
        4'h9: begin r = 8'((a * 2) % 256); mC = (a >= 128); end
        4'hA: begin r = 8'(a / 2); mC = (a % 2 == 1); end
        4'hB: begin r = 8'(a - b); mC = (a < b); writeAcc = 0; end
`ifdef ALU_MUL_EN
        4'hC: begin
          mProd = 16'(a * b);
          mRemain = 8;
          mBusy = 1;
          mDone = 0;
          flagsZn = 0;
          writeAcc = 0;
        end
`endif
        default: begin flagsZn = 0; writeAcc = 0; end
      endcase
      if (writeAcc) mAcc = r;
      if (flagsZn) begin mZ = (r == 0); mN = r[7]; end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEnable) begin
      testsRun++;
      if (accOut !== mAcc || mulHi !== mHi || zFlag !== mZ || cFlag !== mC ||
          nFlag !== mN || busy !== mBusy || done !== mDone) begin
        testsFailed++;
        $display("[TB] FAIL cycle t=%0t got acc=%h hi=%h z%b c%b n%b busy%b done%b, want acc=%h hi=%h z%b c%b n%b busy%b done%b",
                 $time, accOut, mulHi, zFlag, cFlag, nFlag, busy, done,
                 mAcc, mHi, mZ, mC, mN, mBusy, mDone);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s got %h want %h", name, actual, expected);
    end
  endtask

  // One-cycle EN pulse; returns at the negedge after the sampling edge.
  task automatic applyStimulus(input logic [3:0] opc, input logic [7:0] data);
    en = 1'b1;
    op = opc;
    aluData = data;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic waitIdle();
    int guard = 0;
    while (busy === 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("waitIdle", {15'd0, busy}, 16'd0);
  endtask

  task automatic checkFlags(input string name, input logic [7:0] accExp,
                            input logic zExp, input logic cExp, input logic nExp);
    checkOutput({name, " acc"}, {8'h00, accOut}, {8'h00, accExp});
    checkOutput({name, " zcn"}, {13'd0, zFlag, cFlag, nFlag}, {13'd0, zExp, cExp, nExp});
  endtask

  initial begin
    int busyCnt, doneCnt;
    rst = 1'b1; en = 1'b0; op = 4'h0; aluData = 8'h00;
    @(negedge clk);
    @(negedge clk);
    checkEnable = 1'b1;
    rst = 1'b0;
    checkFlags("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("reset busy/done/hi", {6'd0, busy, done, mulHi}, 16'h0000);

    applyStimulus(4'h1, 8'h7F);
    applyStimulus(4'h2, 8'h01);
    checkFlags("add 7f+01", 8'h80, 1'b0, 1'b0, 1'b1);
    checkOutput("add done latency", {15'd0, done}, 16'd1);
    applyStimulus(4'h2, 8'h80);
    checkFlags("add 80+80", 8'h00, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'h3, 8'h01);
    checkFlags("adc 00+01+c", 8'h02, 1'b0, 1'b0, 1'b0);

    applyStimulus(4'h1, 8'h10);
    applyStimulus(4'h4, 8'h20);
    checkFlags("sub 10-20", 8'hF0, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'hB, 8'hF0);
    checkFlags("cmp f0", 8'hF0, 1'b1, 1'b0, 1'b0);

    applyStimulus(4'h1, 8'h81);
    applyStimulus(4'h9, 8'h00);
    checkFlags("shl 81", 8'h02, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'hA, 8'h00);
    checkFlags("shr 02", 8'h01, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h5, 8'h00);
    checkFlags("and 00", 8'h00, 1'b1, 1'b0, 1'b0);

    // Back-to-back single-cycle ops with EN held every cycle.
    en = 1'b1; op = 4'h6; aluData = 8'h0F;
    @(negedge clk);
    op = 4'h7; aluData = 8'hFF;
    @(negedge clk);
    op = 4'h8;
    @(negedge clk);
    en = 1'b0;
    checkFlags("or/xor/not chain", 8'h0F, 1'b0, 1'b0, 1'b0);
    checkOutput("chain done", {15'd0, done}, 16'd1);
    applyStimulus(4'h0, 8'hAA);
    checkFlags("nop", 8'h0F, 1'b0, 1'b0, 1'b0);
    checkOutput("nop done", {15'd0, done}, 16'd1);

`ifdef ALU_MUL_EN
    applyStimulus(4'h1, 8'hFF);
    applyStimulus(4'hC, 8'hFF);
    busyCnt = (busy === 1'b1) ? 1 : 0;
    doneCnt = 0;
    for (int j = 0; j < 10; j++) begin
      if (j == 2) begin en = 1'b1; op = 4'h2; aluData = 8'h01; end
      else en = 1'b0;
      @(negedge clk);
      if (busy === 1'b1) busyCnt++;
      if (done === 1'b1) doneCnt++;
    end
    checkOutput("mul busy cycles", 16'(busyCnt), 16'd8);
    checkOutput("mul done pulses", 16'(doneCnt), 16'd1);
    checkOutput("mul hi", {8'h00, mulHi}, 16'h00FE);
    checkFlags("mul ff*ff", 8'h01, 1'b0, 1'b1, 1'b1);

    applyStimulus(4'h1, 8'h05);
    applyStimulus(4'hC, 8'h03);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkFlags("mul reset", 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("mul reset busy/done/hi", {6'd0, busy, done, mulHi}, 16'h0000);
    repeat (10) @(negedge clk);
    applyStimulus(4'h1, 8'h05);
    applyStimulus(4'hC, 8'h03);
    waitIdle();
    checkOutput("mul 5*3 hi", {8'h00, mulHi}, 16'h0000);
    checkFlags("mul 5*3", 8'h0F, 1'b0, 1'b0, 1'b0);
`else
    applyStimulus(4'h1, 8'h12);
    applyStimulus(4'hC, 8'h34);
    checkFlags("op c nop", 8'h12, 1'b0, 1'b0, 1'b0);
    checkOutput("op c busy/done/hi", {6'd0, busy, done, mulHi}, 16'h0100);
    applyStimulus(4'hF, 8'h34);
    checkFlags("op f nop", 8'h12, 1'b0, 1'b0, 1'b0);
    checkOutput("op f busy/done/hi", {6'd0, busy, done, mulHi}, 16'h0100);
    waitIdle();
`endif

    @(negedge clk);
    checkEnable = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
